rank_filter_3x3: RTL and testbench

- Streaming 3x3 rank-order filter for the pixel pipeline, parametrised in sample width.
- Takes one 3-pixel column per accepted beat, from three line-buffer taps, and keeps a sliding 3x3 window.
- Per-pixel mode selects median, min, max or centre pass-through.
- Per-pixel valid tag with line-start flush, so gaps in the input stream and line boundaries are handled without a one-shot done counter.

---
 rtl/rank_filter_pkg.sv | 15 +
 rtl/rank_filter_3x3_sort3_reg.sv | 54 +++++
 rtl/rank_filter_3x3.sv | 240 ++++++++++++++++++++++++
 tb/tb_rank_filter_3x3.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared encodings and constants for the 3x3 rank-order filter.
package rank_filter_pkg;

    // Per-pixel filter selection, carried alongside each beat.
    typedef enum logic [1:0] {
        MODE_MED  = 2'b00,
        MODE_MIN  = 2'b01,
        MODE_MAX  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    // Clock edges from the edge that samples a beat to the edge that presents its result.
    localparam int PIPE_LAT = 4;

endpackage

// File: rtl/rank_filter_3x3_sort3_reg.sv
// Registered three-input sorter: one cycle after a/b/c are presented,
// max/med/min hold the ordered values (unsigned compare).
module sort3_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] med,
    output logic [DATA_W-1:0] min
);

    logic [DATA_W-1:0] hi_ab;
    logic [DATA_W-1:0] lo_ab;
    logic [DATA_W-1:0] lo_hi_c;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] med_next;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] med_reg;
    logic [DATA_W-1:0] min_reg;

    // Order a/b first, then place c; the median is the larger of the low pair
    // value and the smaller of (high pair value, c). Ties resolve to equal values.
    always_comb begin
        hi_ab    = (a > b) ? a : b;
        lo_ab    = (a > b) ? b : a;
        lo_hi_c  = (hi_ab < c) ? hi_ab : c;
        max_next = (hi_ab > c) ? hi_ab : c;
        min_next = (lo_ab < c) ? lo_ab : c;
        med_next = (lo_hi_c > lo_ab) ? lo_hi_c : lo_ab;
    end

    // Capture the sorted triple.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg <= '0;
            med_reg <= '0;
            min_reg <= '0;
        end else begin
            max_reg <= max_next;
            med_reg <= med_next;
            min_reg <= min_next;
        end
    end

    assign max = max_reg;
    assign med = med_reg;
    assign min = min_reg;

endmodule

// File: rtl/rank_filter_3x3.sv
// Streaming 3x3 rank-order filter. One 3-pixel column enters per valid beat;
// a sliding window of three columns feeds a fixed sorting network whose
// result appears PIPE_LAT edges after the sampling edge, qualified by a
// valid tag that travels with the data.
module rank_filter_3x3
    import rank_filter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              sol_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    // ------------------------------------------------------------------
    // S0: column window and line tracking
    // ------------------------------------------------------------------
    // win_reg[col][row]; column 0 is the newest, column 1 holds the centre.
    logic [DATA_W-1:0] win_reg [3][3];
    logic [DATA_W-1:0] col_in  [3];
    logic [1:0]        col_cnt_reg;
    logic [1:0]        col_cnt_next;
    logic              in_line_reg;
    logic              in_line_next;
    logic              en0;

    assign col_in[0] = d1_i;
    assign col_in[1] = d2_i;
    assign col_in[2] = d3_i;

    // Column counter saturates at 2; a result is only due once a full window
    // belongs to a line that was opened by a start-of-line beat.
    always_comb begin
        col_cnt_next = col_cnt_reg;
        in_line_next = in_line_reg;
        en0          = valid_i & ~sol_i & in_line_reg & (col_cnt_reg == 2'd2);
        if (valid_i) begin
            if (sol_i) begin
                col_cnt_next = 2'd1;
                in_line_next = 1'b1;
            end else if (col_cnt_reg != 2'd2) begin
                col_cnt_next = col_cnt_reg + 2'd1;
            end
        end
    end

    // Line tracking state.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_reg <= 2'd0;
            in_line_reg <= 1'b0;
        end else begin
            col_cnt_reg <= col_cnt_next;
            in_line_reg <= in_line_next;
        end
    end

    // Each window row shifts by one column on every accepted beat.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            always_ff @(posedge clk) begin
                if (rst) begin
                    win_reg[0][gi] <= '0;
                    win_reg[1][gi] <= '0;
                    win_reg[2][gi] <= '0;
                end else if (valid_i) begin
                    win_reg[0][gi] <= col_in[gi];
                    win_reg[1][gi] <= win_reg[0][gi];
                    win_reg[2][gi] <= win_reg[1][gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tag pipeline: valid, mode and centre pixel ride alongside the data
    // ------------------------------------------------------------------
    logic [3:0]        vld_pipe_reg;     // [0]=S0 ... [3]=S3
    mode_e             mode_pipe_reg [4];
    logic [DATA_W-1:0] centre_pipe_reg [3]; // [0]=S1 ... [2]=S3

    // Advance the tags one stage per clock; the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                mode_pipe_reg[i] <= MODE_MED;
            end
            for (int i = 0; i < 3; i++) begin
                centre_pipe_reg[i] <= '0;
            end
        end else begin
            vld_pipe_reg <= {vld_pipe_reg[2:0], en0};
            if (valid_i) begin
                mode_pipe_reg[0] <= mode_e'(mode_i);
            end
            for (int i = 1; i < 4; i++) begin
                mode_pipe_reg[i] <= mode_pipe_reg[i-1];
            end
            centre_pipe_reg[0] <= win_reg[1][1];
            centre_pipe_reg[1] <= centre_pipe_reg[0];
            centre_pipe_reg[2] <= centre_pipe_reg[1];
        end
    end

    // ------------------------------------------------------------------
    // S1: sort each window row
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] row_max [3];
    logic [DATA_W-1:0] row_med [3];
    logic [DATA_W-1:0] row_min [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row_sort
            sort3_reg #(.DATA_W(DATA_W)) u_row_sort (
                .clk (clk),
                .rst (rst),
                .a   (win_reg[0][gi]),
                .b   (win_reg[1][gi]),
                .c   (win_reg[2][gi]),
                .max (row_max[gi]),
                .med (row_med[gi]),
                .min (row_min[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // S2: sort across the row results
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] max_of_max;
    logic [DATA_W-1:0] min_of_max;
    logic [DATA_W-1:0] med_of_med;
    logic [DATA_W-1:0] max_of_min;
    logic [DATA_W-1:0] min_of_min;
    logic [DATA_W-1:0] s2_max_med_unused;
    logic [DATA_W-1:0] s2_med_max_unused;
    logic [DATA_W-1:0] s2_med_min_unused;
    logic [DATA_W-1:0] s2_min_med_unused;

    sort3_reg #(.DATA_W(DATA_W)) u_sort_max (
        .clk (clk),
        .rst (rst),
        .a   (row_max[0]),
        .b   (row_max[1]),
        .c   (row_max[2]),
        .max (max_of_max),
        .med (s2_max_med_unused),
        .min (min_of_max)
    );

    sort3_reg #(.DATA_W(DATA_W)) u_sort_med (
        .clk (clk),
        .rst (rst),
        .a   (row_med[0]),
        .b   (row_med[1]),
        .c   (row_med[2]),
        .max (s2_med_max_unused),
        .med (med_of_med),
        .min (s2_med_min_unused)
    );

    sort3_reg #(.DATA_W(DATA_W)) u_sort_min (
        .clk (clk),
        .rst (rst),
        .a   (row_min[0]),
        .b   (row_min[1]),
        .c   (row_min[2]),
        .max (max_of_min),
        .med (s2_min_med_unused),
        .min (min_of_min)
    );

    // ------------------------------------------------------------------
    // S3: final median, with min/max held in step with it
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] median_s3;
    logic [DATA_W-1:0] min_s3_reg;
    logic [DATA_W-1:0] max_s3_reg;
    logic [DATA_W-1:0] s3_max_unused;
    logic [DATA_W-1:0] s3_min_unused;

    sort3_reg #(.DATA_W(DATA_W)) u_sort_final (
        .clk (clk),
        .rst (rst),
        .a   (min_of_max),
        .b   (med_of_med),
        .c   (max_of_min),
        .max (s3_max_unused),
        .med (median_s3),
        .min (s3_min_unused)
    );

    // Delay the global extremes by one stage to line up with the final median.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_s3_reg <= '0;
            max_s3_reg <= '0;
        end else begin
            min_s3_reg <= min_of_min;
            max_s3_reg <= max_of_max;
        end
    end

    // ------------------------------------------------------------------
    // Output: mode select; data_o holds between results
    // ------------------------------------------------------------------
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    // Register the selected result only for tagged beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= vld_pipe_reg[3];
            if (vld_pipe_reg[3]) begin
                case (mode_pipe_reg[3])
                    MODE_MED:  data_reg <= median_s3;
                    MODE_MIN:  data_reg <= min_s3_reg;
                    MODE_MAX:  data_reg <= max_s3_reg;
                    MODE_PASS: data_reg <= centre_pipe_reg[2];
                    default:   data_reg <= median_s3;
                endcase
            end
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3: an 8-bit and a 10-bit instance share
// control inputs; every clock the outputs of both are logged one tick per
// entry so scenario tasks can compare them against hand-computed vectors.
module tb_rank_filter_3x3;
    import rank_filter_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       sol;
    logic [1:0] mode;
    logic [7:0] d1, d2, d3;
    logic [9:0] w1, w2, w3;
    logic       valid_o8;
    logic [7:0] data_o8;
    logic       valid_ow;
    logic [9:0] data_ow;

    int tests_run;
    int fail_cnt;

    logic       obs_v[$];
    logic [7:0] obs_d[$];
    logic       obs_vw[$];
    logic [9:0] obs_dw[$];

    rank_filter_3x3 #(.DATA_W(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid),
        .sol_i   (sol),
        .mode_i  (mode),
        .d1_i    (d1),
        .d2_i    (d2),
        .d3_i    (d3),
        .valid_o (valid_o8),
        .data_o  (data_o8)
    );

    rank_filter_3x3 #(.DATA_W(10)) dut10 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid),
        .sol_i   (sol),
        .mode_i  (mode),
        .d1_i    (w1),
        .d2_i    (w2),
        .d3_i    (w3),
        .valid_o (valid_ow),
        .data_o  (data_ow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle of inputs, clock it, log outputs 1 ns after the edge.
    task automatic drive(input logic v, input logic s, input logic [1:0] m,
                         input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        valid = v; sol = s; mode = m;
        w1 = a; w2 = b; w3 = c;
        d1 = a[7:0]; d2 = b[7:0]; d3 = c[7:0];
        @(posedge clk);
        #1;
        obs_v.push_back(valid_o8);
        obs_d.push_back(data_o8);
        obs_vw.push_back(valid_ow);
        obs_dw.push_back(data_ow);
        $display("[TB] t=%0t v=%0b sol=%0b mode=%0d col=(%0d,%0d,%0d) -> valid_o=%0b data_o=%0d | w: valid_o=%0b data_o=%0d",
                 $time, v, s, m, a, b, c, valid_o8, data_o8, valid_ow, data_ow);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 10'd0, 10'd0, 10'd0);
    endtask

    task automatic clear_obs();
        obs_v.delete(); obs_d.delete(); obs_vw.delete(); obs_dw.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_obs();
        drive(1'b1, 1'b1, 2'b00, 10'd9, 10'd9, 10'd9);
        drive(1'b1, 1'b0, 2'b00, 10'd9, 10'd9, 10'd9);
        rst = 1'b0;
        tests_run++;
        if (obs_v[1] !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_valid: got %0b expected 0", obs_v[1]);
        end
        tests_run++;
        if (obs_d[1] !== 8'd0) begin
            fail_cnt++; $display("FAIL reset_data: got %0d expected 0", obs_d[1]);
        end
    endtask

    // Window rows {9,1,5},{3,7,2},{8,4,6}: median 5, one result only.
    task automatic test_median();
        clear_obs();
        drive(1'b1, 1'b1, 2'b00, 10'd9, 10'd3, 10'd8);
        drive(1'b1, 1'b0, 2'b00, 10'd1, 10'd7, 10'd4);
        drive(1'b1, 1'b0, 2'b00, 10'd5, 10'd2, 10'd6);
        idle(6);
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (obs_v[i] !== (i == 2 + PIPE_LAT)) begin
                fail_cnt++; $display("FAIL median_valid[%0d]: got %0b expected %0b", i, obs_v[i], (i == 2 + PIPE_LAT));
            end
        end
        tests_run++;
        if (obs_d[6] !== 8'd5) begin
            fail_cnt++; $display("FAIL median_data: got %0d expected 5", obs_d[6]);
        end
        tests_run++;
        if (obs_d[8] !== 8'd5) begin
            fail_cnt++; $display("FAIL median_hold: got %0d expected 5", obs_d[8]);
        end
    endtask

    // Same window with min/max/pass selected only on the result beat.
    task automatic test_mode_sweep();
        logic [1:0] modes [3];
        logic [7:0] expv  [3];
        modes = '{2'b01, 2'b10, 2'b11};
        expv  = '{8'd1, 8'd9, 8'd7};
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            drive(1'b1, 1'b1, 2'b00, 10'd9, 10'd3, 10'd8);
            drive(1'b1, 1'b0, 2'b00, 10'd1, 10'd7, 10'd4);
            drive(1'b1, 1'b0, modes[k], 10'd5, 10'd2, 10'd6);
            idle(5);
            tests_run++;
            if (obs_v[5] !== 1'b0 || obs_v[6] !== 1'b1 || obs_v[7] !== 1'b0) begin
                fail_cnt++; $display("FAIL mode%0d_valid: got %0b%0b%0b expected 010", modes[k], obs_v[5], obs_v[6], obs_v[7]);
            end
            tests_run++;
            if (obs_d[6] !== expv[k]) begin
                fail_cnt++; $display("FAIL mode%0d_data: got %0d expected %0d", modes[k], obs_d[6], expv[k]);
            end
        end
    endtask

    // 5-beat line then 4-beat line, back to back: results 50,80,100 then 8,6.
    task automatic test_line_restart();
        logic       ev [15];
        logic [7:0] ed [15];
        clear_obs();
        drive(1'b1, 1'b1, 2'b00, 10'd10,  10'd20,  10'd30);
        drive(1'b1, 1'b0, 2'b00, 10'd40,  10'd50,  10'd60);
        drive(1'b1, 1'b0, 2'b00, 10'd70,  10'd80,  10'd90);
        drive(1'b1, 1'b0, 2'b00, 10'd200, 10'd210, 10'd220);
        drive(1'b1, 1'b0, 2'b00, 10'd100, 10'd5,   10'd250);
        drive(1'b1, 1'b1, 2'b00, 10'd9,   10'd9,   10'd9);
        drive(1'b1, 1'b0, 2'b00, 10'd8,   10'd8,   10'd8);
        drive(1'b1, 1'b0, 2'b00, 10'd5,   10'd5,   10'd5);
        drive(1'b1, 1'b0, 2'b00, 10'd6,   10'd6,   10'd6);
        idle(6);
        ev = '{0,0,0,0,0,0,1,1,1,0,0,1,1,0,0};
        ed = '{0,0,0,0,0,0,50,80,100,100,100,8,6,6,6};
        for (int i = 0; i < 15; i++) begin
            tests_run++;
            if (obs_v[i] !== ev[i]) begin
                fail_cnt++; $display("FAIL line_valid[%0d]: got %0b expected %0b", i, obs_v[i], ev[i]);
            end
            if (i >= 6) begin
                tests_run++;
                if (obs_d[i] !== ed[i]) begin
                    fail_cnt++; $display("FAIL line_data[%0d]: got %0d expected %0d", i, obs_d[i], ed[i]);
                end
            end
        end
    endtask

    // Pattern 1,0,0,1,1,0,1 after fill; gap cycles carry junk and a stray sol.
    task automatic test_gapped();
        logic       ev [15];
        logic [7:0] ed [15];
        clear_obs();
        drive(1'b1, 1'b1, 2'b00, 10'd1,  10'd2,  10'd3);
        drive(1'b1, 1'b0, 2'b00, 10'd4,  10'd5,  10'd6);
        drive(1'b1, 1'b0, 2'b00, 10'd7,  10'd8,  10'd9);
        drive(1'b0, 1'b1, 2'b11, 10'd255, 10'd255, 10'd255);
        drive(1'b0, 1'b0, 2'b10, 10'd255, 10'd255, 10'd255);
        drive(1'b1, 1'b0, 2'b00, 10'd10, 10'd11, 10'd12);
        drive(1'b1, 1'b0, 2'b00, 10'd13, 10'd14, 10'd15);
        drive(1'b0, 1'b0, 2'b01, 10'd0,  10'd0,  10'd0);
        drive(1'b1, 1'b0, 2'b00, 10'd16, 10'd17, 10'd18);
        idle(6);
        ev = '{0,0,0,0,0,0,1,0,0,1,1,0,1,0,0};
        ed = '{0,0,0,0,0,0,5,5,5,8,11,11,14,14,14};
        for (int i = 0; i < 15; i++) begin
            tests_run++;
            if (obs_v[i] !== ev[i]) begin
                fail_cnt++; $display("FAIL gap_valid[%0d]: got %0b expected %0b", i, obs_v[i], ev[i]);
            end
            if (i >= 6) begin
                tests_run++;
                if (obs_d[i] !== ed[i]) begin
                    fail_cnt++; $display("FAIL gap_data[%0d]: got %0d expected %0d", i, obs_d[i], ed[i]);
                end
            end
        end
    endtask

    // Reset with three results in flight, then non-sol beats, then a new line.
    task automatic test_reset_midstream();
        clear_obs();
        drive(1'b1, 1'b1, 2'b00, 10'd100, 10'd100, 10'd100);
        drive(1'b1, 1'b0, 2'b00, 10'd110, 10'd110, 10'd110);
        drive(1'b1, 1'b0, 2'b00, 10'd120, 10'd120, 10'd120);
        drive(1'b1, 1'b0, 2'b00, 10'd130, 10'd130, 10'd130);
        drive(1'b1, 1'b0, 2'b00, 10'd140, 10'd140, 10'd140);
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 10'd0, 10'd0, 10'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 10'd50, 10'd50, 10'd50);
        drive(1'b1, 1'b0, 2'b00, 10'd60, 10'd60, 10'd60);
        drive(1'b1, 1'b0, 2'b00, 10'd70, 10'd70, 10'd70);
        drive(1'b1, 1'b1, 2'b00, 10'd9, 10'd3, 10'd8);
        drive(1'b1, 1'b0, 2'b00, 10'd1, 10'd7, 10'd4);
        drive(1'b1, 1'b0, 2'b10, 10'd5, 10'd2, 10'd6);
        idle(6);
        for (int i = 0; i < 18; i++) begin
            tests_run++;
            if (obs_v[i] !== (i == 11 + PIPE_LAT)) begin
                fail_cnt++; $display("FAIL rst_mid_valid[%0d]: got %0b expected %0b", i, obs_v[i], (i == 11 + PIPE_LAT));
            end
        end
        for (int i = 5; i < 15; i++) begin
            tests_run++;
            if (obs_d[i] !== 8'd0) begin
                fail_cnt++; $display("FAIL rst_mid_data[%0d]: got %0d expected 0", i, obs_d[i]);
            end
        end
        tests_run++;
        if (obs_d[15] !== 8'd9) begin
            fail_cnt++; $display("FAIL rst_mid_result: got %0d expected 9", obs_d[15]);
        end
    endtask

    // 10-bit instance: values 1023, 0 and three 512s; no truncation allowed.
    task automatic test_wide();
        logic [1:0] modes [4];
        logic [9:0] expv  [4];
        modes = '{2'b00, 2'b01, 2'b10, 2'b11};
        expv  = '{10'd512, 10'd0, 10'd1023, 10'd1023};
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            drive(1'b1, 1'b1, 2'b00, 10'd1023, 10'd512,  10'd0);
            drive(1'b1, 1'b0, 2'b00, 10'd512,  10'd1023, 10'd0);
            drive(1'b1, 1'b0, modes[k], 10'd512, 10'd700, 10'd1);
            idle(5);
            tests_run++;
            if (obs_vw[6] !== 1'b1 || obs_vw[5] !== 1'b0) begin
                fail_cnt++; $display("FAIL wide%0d_valid: got %0b%0b expected 01", modes[k], obs_vw[5], obs_vw[6]);
            end
            tests_run++;
            if (obs_dw[6] !== expv[k]) begin
                fail_cnt++; $display("FAIL wide%0d_data: got %0d expected %0d", modes[k], obs_dw[6], expv[k]);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        rst = 1'b1; valid = 1'b0; sol = 1'b0; mode = 2'b00;
        d1 = '0; d2 = '0; d3 = '0; w1 = '0; w2 = '0; w3 = '0;
        test_reset();
        test_median();
        test_mode_sweep();
        test_line_restart();
        test_gapped();
        test_reset_midstream();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
